// File: rtl/mem_intv_delay_stage.sv
// Val/rdy throttle: a small FIFO whose output transfers are spaced at least
// p_intv_delay cycles apart. It is used to add configurable memory timing.
module mem_intv_delay_stage #(
  parameter int p_msg_bits   = 32,
  parameter int p_intv_delay = 1,
  parameter int p_buf_depth  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  istream_val,
  output logic                  istream_rdy,
  input  logic [p_msg_bits-1:0] istream_msg,
  output logic                  ostream_val,
  input  logic                  ostream_rdy,
  output logic [p_msg_bits-1:0] ostream_msg,
  output logic [4:0]            occupancy
);

  localparam int                    c_ptr_bits = (p_buf_depth > 1) ? $clog2(p_buf_depth) : 1;
  localparam logic [c_ptr_bits-1:0] c_ptr_last = c_ptr_bits'(p_buf_depth - 1);
  localparam logic [4:0]            c_depth    = 5'(p_buf_depth);
  localparam logic [7:0]            c_cnt_load = 8'(p_intv_delay - 1);

  generate
    if (p_intv_delay < 1 || p_intv_delay > 255) begin : g_bad_intv
      $error("mem_intv_delay_stage: p_intv_delay must be in 1..255");
    end
    if (p_buf_depth < 1 || p_buf_depth > 16) begin : g_bad_depth
      $error("mem_intv_delay_stage: p_buf_depth must be in 1..16");
    end
  endgenerate

  logic [p_msg_bits-1:0] r_mem [p_buf_depth];
  logic [c_ptr_bits-1:0] r_head;
  logic [c_ptr_bits-1:0] r_tail;
  logic [4:0]            r_occ;
  logic [7:0]            r_cnt;

  logic w_in_xfer;
  logic w_out_xfer;

  // Both handshake outputs come from registered state only, so there is no
  // combinational path between the two streams.
  assign istream_rdy = !rst && (r_occ < c_depth);
  assign ostream_val = !rst && (r_occ != 5'd0) && (r_cnt == 8'd0);
  assign ostream_msg = r_mem[r_head];
  assign occupancy   = r_occ;

  assign w_in_xfer  = istream_val && istream_rdy;
  assign w_out_xfer = ostream_val && ostream_rdy;

  // Pointers wrap modulo the depth, which need not be a power of two.
  function automatic logic [c_ptr_bits-1:0] f_ptr_inc(input logic [c_ptr_bits-1:0] ptr);
    return (ptr == c_ptr_last) ? '0 : ptr + 1'b1;
  endfunction

  // Storage has no reset: entries are only observed while occupancy covers them.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_mem[r_tail] <= istream_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 5'd0;
    end else begin
      if (w_in_xfer) begin
        r_tail <= f_ptr_inc(r_tail);
      end
      if (w_out_xfer) begin
        r_head <= f_ptr_inc(r_head);
      end
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_occ <= r_occ + 5'd1;
        2'b01:   r_occ <= r_occ - 5'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Interval counter: reloaded on each output transfer, then counts down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (w_out_xfer) begin
      r_cnt <= c_cnt_load;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_intv_delay_stage.sv
// Bench for mem_intv_delay_stage: three instances with different interval and
// depth settings, checked with per-instance scoreboards of expected messages.
module tb_mem_intv_delay_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // A: interval 1, depth 2.  B: interval 3, depth 2.  C: interval 1, depth 3.
  logic        a_ival, a_irdy, a_oval, a_ordy;
  logic [31:0] a_imsg, a_omsg;
  logic [4:0]  a_occ;
  logic        b_ival, b_irdy, b_oval, b_ordy;
  logic [31:0] b_imsg, b_omsg;
  logic [4:0]  b_occ;
  logic        c_ival, c_irdy, c_oval, c_ordy;
  logic [31:0] c_imsg, c_omsg;
  logic [4:0]  c_occ;

  mem_intv_delay_stage #(.p_msg_bits(32), .p_intv_delay(1), .p_buf_depth(2)) dut_a (
    .clk(clk), .rst(rst),
    .istream_val(a_ival), .istream_rdy(a_irdy), .istream_msg(a_imsg),
    .ostream_val(a_oval), .ostream_rdy(a_ordy), .ostream_msg(a_omsg),
    .occupancy(a_occ)
  );

  mem_intv_delay_stage #(.p_msg_bits(32), .p_intv_delay(3), .p_buf_depth(2)) dut_b (
    .clk(clk), .rst(rst),
    .istream_val(b_ival), .istream_rdy(b_irdy), .istream_msg(b_imsg),
    .ostream_val(b_oval), .ostream_rdy(b_ordy), .ostream_msg(b_omsg),
    .occupancy(b_occ)
  );

  mem_intv_delay_stage #(.p_msg_bits(32), .p_intv_delay(1), .p_buf_depth(3)) dut_c (
    .clk(clk), .rst(rst),
    .istream_val(c_ival), .istream_rdy(c_irdy), .istream_msg(c_imsg),
    .ostream_val(c_oval), .ostream_rdy(c_ordy), .ostream_msg(c_omsg),
    .occupancy(c_occ)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  // Inputs are driven just after the falling edge and outputs sampled 1ns later.
  task automatic test_reset();
    rst = 1'b1;
    a_ival = 1'b1; b_ival = 1'b1; c_ival = 1'b1;
    a_imsg = 32'hDEAD; b_imsg = 32'hDEAD; c_imsg = 32'hDEAD;
    a_ordy = 1'b0; b_ordy = 1'b0; c_ordy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({a_irdy, b_irdy, c_irdy} !== 3'b000) begin
        n_mis++;
        $display("FAIL reset_irdy cycle %0d: got %b, want 000", i, {a_irdy, b_irdy, c_irdy});
      end
      n_cmp++;
      if ({a_oval, b_oval, c_oval} !== 3'b000) begin
        n_mis++;
        $display("FAIL reset_oval cycle %0d: got %b, want 000", i, {a_oval, b_oval, c_oval});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    a_ival = 1'b0; b_ival = 1'b0; c_ival = 1'b0;
    #1;
    n_cmp++;
    if ({a_irdy, b_irdy, c_irdy} !== 3'b111) begin
      n_mis++;
      $display("FAIL post_reset_irdy: got %b, want 111", {a_irdy, b_irdy, c_irdy});
    end
    n_cmp++;
    if (a_occ !== 5'd0 || b_occ !== 5'd0 || c_occ !== 5'd0) begin
      n_mis++;
      $display("FAIL post_reset_occ: got %0d/%0d/%0d, want 0/0/0", a_occ, b_occ, c_occ);
    end
    n_cmp++;
    if ({a_oval, b_oval, c_oval} !== 3'b000) begin
      n_mis++;
      $display("FAIL post_reset_oval: got %b, want 000", {a_oval, b_oval, c_oval});
    end
    $display("reset: done");
  endtask

  task automatic test_back_to_back();
    int outs = 0;
    logic [31:0] exp;
    a_ordy = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      a_ival = (cyc < 4);
      a_imsg = 32'h11 * (cyc + 1);
      #1;
      n_cmp++;
      if (a_occ > 5'd1 || $isunknown(a_occ)) begin
        n_mis++;
        $display("FAIL b2b_occ cycle %0d: got %0d, want <=1", cyc, a_occ);
      end
      if (a_oval && a_ordy) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_mis++;
          $display("FAIL b2b_spurious cycle %0d: got msg %h, want no output", cyc, a_omsg);
        end else begin
          exp = qa.pop_front();
          if (a_omsg !== exp) begin
            n_mis++;
            $display("FAIL b2b_msg cycle %0d: got %h, want %h", cyc, a_omsg, exp);
          end
        end
        n_cmp++;
        if (cyc != outs + 1) begin
          n_mis++;
          $display("FAIL b2b_timing output %0d: got cycle %0d, want cycle %0d", outs, cyc, outs + 1);
        end
        $display("b2b: out %h at cycle %0d", a_omsg, cyc);
        outs++;
      end
      if (a_ival && a_irdy) qa.push_back(a_imsg);
    end
    n_cmp++;
    if (outs != 4) begin
      n_mis++;
      $display("FAIL b2b_count: got %0d outputs, want 4", outs);
    end
    a_ival = 1'b0;
    a_ordy = 1'b0;
  endtask

  task automatic test_interval();
    logic exp_val;
    logic [31:0] exp;
    b_ordy = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      b_ival = (cyc < 3);
      b_imsg = 32'hA0 + 32'(cyc);
      #1;
      exp_val = (cyc == 1 || cyc == 4 || cyc == 7);
      n_cmp++;
      if (b_oval !== exp_val) begin
        n_mis++;
        $display("FAIL intv_val cycle %0d: got %b, want %b", cyc, b_oval, exp_val);
      end
      if (b_oval && b_ordy) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_mis++;
          $display("FAIL intv_spurious cycle %0d: got msg %h, want no output", cyc, b_omsg);
        end else begin
          exp = qb.pop_front();
          if (b_omsg !== exp) begin
            n_mis++;
            $display("FAIL intv_msg cycle %0d: got %h, want %h", cyc, b_omsg, exp);
          end
        end
        $display("intv: out %h at cycle %0d", b_omsg, cyc);
      end
      if (b_ival && b_irdy) qb.push_back(b_imsg);
    end
    n_cmp++;
    if (qb.size() != 0) begin
      n_mis++;
      $display("FAIL intv_left: got %0d undelivered, want 0", qb.size());
    end
    b_ival = 1'b0;
    b_ordy = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int outs = 0;
    int cyc = 0;
    logic [31:0] exp;
    while (outs < 3 && cyc < 30) begin
      @(negedge clk);
      a_ival = (sent < 3);
      a_imsg = 32'(sent + 1);
      a_ordy = (cyc >= 6);
      #1;
      if (cyc >= 2 && cyc < 6) begin
        n_cmp++;
        if (a_irdy !== 1'b0 || a_occ !== 5'd2) begin
          n_mis++;
          $display("FAIL bp_full cycle %0d: got rdy=%b occ=%0d, want rdy=0 occ=2", cyc, a_irdy, a_occ);
        end
        n_cmp++;
        if (a_oval !== 1'b1 || a_omsg !== 32'h1) begin
          n_mis++;
          $display("FAIL bp_hold cycle %0d: got val=%b msg=%h, want val=1 msg=00000001", cyc, a_oval, a_omsg);
        end
      end
      if (cyc == 6) begin
        n_cmp++;
        if (a_irdy !== 1'b0) begin
          n_mis++;
          $display("FAIL bp_full_deq: got rdy=%b, want 0 while full and dequeuing", a_irdy);
        end
      end
      if (a_oval && a_ordy) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_mis++;
          $display("FAIL bp_spurious cycle %0d: got msg %h, want no output", cyc, a_omsg);
        end else begin
          exp = qa.pop_front();
          if (a_omsg !== exp) begin
            n_mis++;
            $display("FAIL bp_msg cycle %0d: got %h, want %h", cyc, a_omsg, exp);
          end
        end
        $display("bp: out %h at cycle %0d", a_omsg, cyc);
        outs++;
      end
      if (a_ival && a_irdy) begin
        qa.push_back(a_imsg);
        sent++;
      end
      cyc++;
    end
    n_cmp++;
    if (outs != 3) begin
      n_mis++;
      $display("FAIL bp_count: got %0d outputs in %0d cycles, want 3", outs, cyc);
    end
    a_ival = 1'b0;
    a_ordy = 1'b0;
  endtask

  task automatic test_wrap();
    int sent = 0;
    int rcvd = 0;
    int occ_model = 0;
    int cyc = 0;
    logic [31:0] exp;
    while (rcvd < 50 && cyc < 3000) begin
      @(negedge clk);
      c_ival = (sent < 50) && ($urandom_range(0, 1) == 1);
      c_imsg = 32'(sent);
      c_ordy = ($urandom_range(0, 1) == 1);
      #1;
      n_cmp++;
      if (c_occ !== 5'(occ_model) || c_irdy !== (occ_model < 3)) begin
        n_mis++;
        $display("FAIL wrap_occ cycle %0d: got occ=%0d rdy=%b, want occ=%0d rdy=%b",
                 cyc, c_occ, c_irdy, occ_model, occ_model < 3);
      end
      if (c_oval && c_ordy) begin
        n_cmp++;
        if (qc.size() == 0) begin
          n_mis++;
          $display("FAIL wrap_spurious cycle %0d: got msg %h, want no output", cyc, c_omsg);
        end else begin
          exp = qc.pop_front();
          if (c_omsg !== exp) begin
            n_mis++;
            $display("FAIL wrap_msg cycle %0d: got %h, want %h", cyc, c_omsg, exp);
          end
        end
        rcvd++;
        occ_model--;
      end
      if (c_ival && c_irdy) begin
        qc.push_back(c_imsg);
        sent++;
        occ_model++;
      end
      cyc++;
    end
    n_cmp++;
    if (rcvd != 50 || qc.size() != 0) begin
      n_mis++;
      $display("FAIL wrap_count: got %0d delivered (%0d pending), want 50 (0)", rcvd, qc.size());
    end
    $display("wrap: %0d messages in %0d cycles", rcvd, cyc);
    c_ival = 1'b0;
    c_ordy = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      rst = (cyc == 3);
      case (cyc)
        0:       begin b_ival = 1'b1; b_imsg = 32'h71; b_ordy = 1'b0; end
        1:       begin b_ival = 1'b1; b_imsg = 32'h72; b_ordy = 1'b1; end
        2:       begin b_ival = 1'b1; b_imsg = 32'h73; b_ordy = 1'b1; end
        5:       begin b_ival = 1'b1; b_imsg = 32'h5A; b_ordy = 1'b1; end
        default: begin b_ival = 1'b0; b_ordy = 1'b1; end
      endcase
      #1;
      if (cyc == 3) begin
        n_cmp++;
        if (b_occ !== 5'd2 || b_irdy !== 1'b0 || b_oval !== 1'b0) begin
          n_mis++;
          $display("FAIL rstmid_during: got occ=%0d rdy=%b val=%b, want occ=2 rdy=0 val=0", b_occ, b_irdy, b_oval);
        end
        qb.delete();
      end
      if (cyc == 4) begin
        n_cmp++;
        if (b_occ !== 5'd0 || b_oval !== 1'b0 || b_irdy !== 1'b1) begin
          n_mis++;
          $display("FAIL rstmid_after: got occ=%0d val=%b rdy=%b, want occ=0 val=0 rdy=1", b_occ, b_oval, b_irdy);
        end
      end
      if (cyc == 6) begin
        n_cmp++;
        if (b_oval !== 1'b1 || b_omsg !== 32'h5A) begin
          n_mis++;
          $display("FAIL rstmid_new: got val=%b msg=%h, want val=1 msg=0000005a", b_oval, b_omsg);
        end
      end
      if (cyc == 7) begin
        n_cmp++;
        if (b_occ !== 5'd0) begin
          n_mis++;
          $display("FAIL rstmid_drain: got occ=%0d, want 0", b_occ);
        end
      end
      if (b_oval && b_ordy) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_mis++;
          $display("FAIL rstmid_spurious cycle %0d: got msg %h, want no output", cyc, b_omsg);
        end else begin
          exp = qb.pop_front();
          if (b_omsg !== exp) begin
            n_mis++;
            $display("FAIL rstmid_msg cycle %0d: got %h, want %h", cyc, b_omsg, exp);
          end
        end
        $display("rstmid: out %h at cycle %0d", b_omsg, cyc);
      end
      if (b_ival && b_irdy) qb.push_back(b_imsg);
    end
    b_ival = 1'b0;
    b_ordy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_interval();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
